// File: rtl/pwm_led_multi.sv
// Multi-channel PWM LED driver: shared prescaler and period counter, per-channel
// double-buffered duty with optional 1-LSB-per-period fade toward the target.
module pwm_led_multi #(
  parameter int CHANNELS = 4,
  parameter int RES      = 8,
  parameter int PRESC_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PRESC_W-1:0]      prescale_i,
  input  logic [CHANNELS*RES-1:0] duty_i,
  input  logic                    load_i,
  input  logic                    fade_en_i,
  output logic [CHANNELS-1:0]     pwm_o,
  output logic                    period_o,
  output logic                    busy_o
);

  localparam logic [RES-1:0]     CNT_MAX   = {RES{1'b1}};
  localparam logic [RES-1:0]     CNT_ONE   = {{(RES-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [PRESC_W-1:0]             presc_cnt_q, presc_cnt_d;
  logic [RES-1:0]                 cnt_q, cnt_d;
  logic [CHANNELS-1:0][RES-1:0]   target_q, target_d;
  logic [CHANNELS-1:0][RES-1:0]   active_q, active_d;
  logic [CHANNELS-1:0]            pwm_q, pwm_d;
  logic                           period_q, period_d;
  logic                           busy_q, busy_d;
  logic                           tick_s;
  logic                           boundary_s;

  // Next-state: prescaler, period counter, duty buffers and output decode
  always_comb begin
    // >= rather than == so lowering prescale_i below the count ticks at once
    tick_s     = (presc_cnt_q >= prescale_i);
    boundary_s = tick_s && (cnt_q == CNT_MAX);
    if (tick_s) begin
      presc_cnt_d = {PRESC_W{1'b0}};
      cnt_d       = cnt_q + CNT_ONE;
    end else begin
      presc_cnt_d = presc_cnt_q + PRESC_ONE;
      cnt_d       = cnt_q;
    end
    target_d = target_q;
    active_d = active_q;
    pwm_d    = {CHANNELS{1'b0}};
    busy_d   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (load_i) begin
        target_d[k] = duty_i[k*RES +: RES];
      end else begin
        target_d[k] = target_q[k];
      end
      // the boundary deliberately reads the old target, so a coincident load waits a period
      if (boundary_s) begin
        if (!fade_en_i) begin
          active_d[k] = target_q[k];
        end else if (active_q[k] < target_q[k]) begin
          active_d[k] = active_q[k] + CNT_ONE;
        end else if (active_q[k] > target_q[k]) begin
          active_d[k] = active_q[k] - CNT_ONE;
        end else begin
          active_d[k] = active_q[k];
        end
      end else begin
        active_d[k] = active_q[k];
      end
      pwm_d[k] = (cnt_d < active_d[k]);
      busy_d   = busy_d | (active_d[k] != target_d[k]);
    end
    period_d = boundary_s;
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt_q <= {PRESC_W{1'b0}};
      cnt_q       <= {RES{1'b0}};
      target_q    <= {(CHANNELS*RES){1'b0}};
      active_q    <= {(CHANNELS*RES){1'b0}};
      pwm_q       <= {CHANNELS{1'b0}};
      period_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      active_q    <= active_d;
      pwm_q       <= pwm_d;
      period_q    <= period_d;
      busy_q      <= busy_d;
    end
  end

  assign pwm_o    = pwm_q;
  assign period_o = period_q;
  assign busy_o   = busy_q;

endmodule
